// File: rtl/matrix_scan_ctrl.sv
// Row-scan sequencer for a 7x5 LED matrix: one-hot row select with dwell and
// blanking gaps, plus a double-buffered frame that swaps only at frame boundaries.
module matrix_scan_ctrl #(
  parameter int unsigned DIV   = 1000,
  parameter int unsigned BLANK = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [34:0] frame_in,
  input  logic        frame_load,
  output logic        frame_ack,
  output logic        frame_start,
  output logic [6:0]  row_sel,
  output logic [2:0]  row_idx,
  output logic [34:0] disp
);

  localparam int unsigned MAXV = (DIV > BLANK) ? DIV : BLANK;
  localparam int unsigned CW   = (MAXV < 2) ? 1 : $clog2(MAXV);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    row_idx_q, row_idx_d;
  logic [6:0]    row_sel_q, row_sel_d;
  logic          ack_q, ack_d;
  logic          fs_q, fs_d;
  logic [34:0]   disp_q, disp_d;
  logic [34:0]   back_q, back_d;
  logic          pend_q, pend_d;
  logic          swap;
  logic [2:0]    nxt_row;

  function automatic logic [6:0] onehot(input logic [2:0] idx);
    onehot = 7'b1 << idx;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    row_idx_d = row_idx_q;
    row_sel_d = row_sel_q;
    fs_d      = 1'b0;
    swap      = 1'b0;
    nxt_row   = (row_idx_q == 3'd6) ? 3'd0 : row_idx_q + 3'd1;
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        row_sel_d = '0;
        row_idx_d = '0;
        if (en) begin
          swap = pend_q;
          if (BLANK == 0) begin
            state_d   = S_DWELL;
            row_sel_d = onehot(3'd0);
            fs_d      = 1'b1;
          end else begin
            state_d = S_BLANK;
          end
        end
      end
      S_BLANK: begin
        if (!en) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          row_sel_d = '0;
          row_idx_d = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d   = S_DWELL;
          cnt_d     = '0;
          row_sel_d = onehot(row_idx_q);
          fs_d      = (row_idx_q == 3'd0);
        end
      end
      S_DWELL: begin
        if (!en) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          row_sel_d = '0;
          row_idx_d = '0;
        end else if (cnt_q == DIV_LAST) begin
          cnt_d     = '0;
          row_idx_d = nxt_row;
          swap      = pend_q && (row_idx_q == 3'd6);
          // With no blanking gap the next row lights on the same edge the old one drops.
          if (BLANK == 0) begin
            row_sel_d = onehot(nxt_row);
            fs_d      = (nxt_row == 3'd0);
          end else begin
            state_d   = S_BLANK;
            row_sel_d = '0;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        row_sel_d = '0;
        row_idx_d = '0;
      end
    endcase
  end

  // A load coinciding with a swap lands in back after the swap reads the old contents.
  always_comb begin
    ack_d  = swap;
    disp_d = swap ? back_q : disp_q;
    back_d = frame_load ? frame_in : back_q;
    pend_d = frame_load | (pend_q & ~swap);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      row_idx_q <= '0;
      row_sel_q <= '0;
      ack_q     <= 1'b0;
      fs_q      <= 1'b0;
      disp_q    <= '0;
      back_q    <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_idx_q <= row_idx_d;
      row_sel_q <= row_sel_d;
      ack_q     <= ack_d;
      fs_q      <= fs_d;
      disp_q    <= disp_d;
      back_q    <= back_d;
      pend_q    <= pend_d;
    end
  end

  assign row_sel     = row_sel_q;
  assign row_idx     = row_idx_q;
  assign frame_ack   = ack_q;
  assign frame_start = fs_q;
  assign disp        = disp_q;

endmodule
